uart_rx_simple: RTL



---
 rtl/uart_rx_simple_if.sv | 22 ++
 rtl/uart_rx_simple.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_simple_if.sv
// Receive-side bundle between the UART receiver and its consumer.
// master drives the line, enable and acknowledge; slave is the receiver.
interface uart_rx_simple_if;
    logic       ena;
    logic       rx;
    logic       rd_ack;
    logic [7:0] data;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    modport master (
        output ena, rx, rd_ack,
        input  data, rx_ready, frame_err, overrun_err, busy
    );

    modport slave (
        input  ena, rx, rd_ack,
        output data, rx_ready, frame_err, overrun_err, busy
    );
endinterface

// File: rtl/uart_rx_simple.sv
// 8N1 LSB-first UART receiver: synchronised line, mid-bit sampling, byte held until rd_ack,
// with framing-error pulse and sticky overrun flag.
module uart_rx_simple #(
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned CNT_W        = 12
) (
    input logic             clk,
    input logic             rst,
    uart_rx_simple_if.slave bus
);

    typedef enum logic [2:0] {StWaitIdle, StIdle, StStart, StData, StStop} state_e;

    localparam logic [CNT_W-1:0] HalfEnd = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BitEnd  = CNT_W'(CLKS_PER_BIT - 1);
    // Three consecutive high samples, so the preset synchroniser alone never looks idle.
    localparam logic [CNT_W-1:0] IdleEnd = CNT_W'(2);

    state_e           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic             rxs;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             rx_ready_q, rx_ready_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy;

    assign rxs = sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else if (bus.ena) begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWaitIdle;
        end else if (bus.ena) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitIdle: if (rxs && cnt_q == IdleEnd) state_d = StIdle;
            StIdle:     if (!rxs) state_d = StStart;
            StStart:    if (cnt_q == HalfEnd) state_d = rxs ? StIdle : StData;
            StData:     if (cnt_q == BitEnd && idx_q == 3'd7) state_d = StStop;
            StStop:     if (cnt_q == BitEnd) state_d = rxs ? StIdle : StWaitIdle;
            default:    state_d = StWaitIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        rx_ready_d  = rx_ready_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        busy        = 1'b0;

        if (bus.rd_ack && rx_ready_q) begin
            rx_ready_d = 1'b0;
            overrun_d  = 1'b0;
        end

        unique case (state_q)
            StWaitIdle: begin
                if (!rxs || cnt_q == IdleEnd) cnt_d = '0;
                else                          cnt_d = cnt_q + 1'b1;
            end
            StIdle: cnt_d = '0;
            StStart: begin
                busy = 1'b1;
                if (cnt_q == HalfEnd) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                busy = 1'b1;
                if (cnt_q == BitEnd) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                busy = 1'b1;
                if (cnt_q == BitEnd) begin
                    cnt_d = '0;
                    if (rxs) begin
                        // A coincident rd_ack consumes the old byte, so the new one wins cleanly.
                        data_d     = shift_q;
                        rx_ready_d = 1'b1;
                        overrun_d  = rx_ready_q && !bus.rd_ack;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            rx_ready_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (bus.ena) begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            rx_ready_q  <= rx_ready_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.rx_ready    = rx_ready_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_q;
    assign bus.busy        = busy;

endmodule
